// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters (packer now, downsizer later).
package stream_pkg;

    typedef enum logic [0:0] {
        ERR_NO_SOP  = 1'b0,
        ERR_DUP_SOP = 1'b1
    } err_code_e;

    function automatic int bytes_of(input int w);
        return w / 8;
    endfunction

    function automatic bit widths_ok(input int in_w, input int out_w);
        return (in_w > 0) && (in_w % 8 == 0) && (out_w % in_w == 0) && (out_w / in_w >= 2);
    endfunction

endpackage

// File: rtl/stream_out_slot.sv
// One-entry registered valid/ready holding slot; a load may coincide with a drain.
module stream_out_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_can_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/stream_packer.sv
// Narrow-to-wide packet upsizer: packs IN_W beats into OUT_W words with sop/eop/empty,
// protocol-error detection and packet/error statistics.
module stream_packer
    import stream_pkg::*;
#(
    parameter  int IN_W  = 32,
    parameter  int OUT_W = 512,
    localparam int IE_W  = ($clog2(IN_W / 8) > 1) ? $clog2(IN_W / 8) : 1,
    localparam int OE_W  = $clog2(OUT_W / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [IE_W-1:0]  in_empty,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [OE_W-1:0]  out_empty,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [15:0]      err_cnt,
    output logic [31:0]      pkt_cnt
);

    localparam int RATIO  = OUT_W / IN_W;
    localparam int CNT_W  = $clog2(RATIO);
    localparam int PAY_W  = OUT_W + OE_W + 2;
    localparam int BEAT_B = bytes_of(IN_W);

    if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
        $error("stream_packer: IN_W must be a byte multiple dividing OUT_W with ratio >= 2");
    end

    logic [OUT_W-1:0] r_acc_data;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_in_pkt;
    logic             r_first_word;
    logic             r_err_pulse;
    logic [15:0]      r_err_cnt;
    logic [31:0]      r_pkt_cnt;

    logic             w_can_load;
    logic             w_beat;
    logic             w_err_nosop;
    logic             w_err_dup;
    logic             w_take;
    logic [CNT_W-1:0] w_lane;
    logic             w_first;
    logic             w_done;
    logic [OUT_W-1:0] w_word;
    logic [OE_W-1:0]  w_eop_empty;
    logic [OE_W-1:0]  w_word_empty;
    logic [PAY_W-1:0] w_load_pay;
    logic [PAY_W-1:0] w_slot_pay;
    logic             w_out_valid;

    assign w_beat      = in_valid && w_can_load;
    assign w_err_nosop = w_beat && !in_sop && !r_in_pkt;
    assign w_err_dup   = w_beat && in_sop && r_in_pkt;
    assign w_take      = w_beat && !w_err_nosop;
    // A sop always restarts at lane 0, which also discards any partial word.
    assign w_lane      = in_sop ? '0 : r_acc_cnt;
    assign w_first     = in_sop || r_first_word;
    assign w_done      = w_take && (in_eop || (w_lane == CNT_W'(RATIO - 1)));

    always_comb begin
        w_word = (w_lane == '0) ? '0 : r_acc_data;
        for (int i = 0; i < RATIO; i++) begin
            if (w_lane == CNT_W'(i)) begin
                w_word[i*IN_W +: IN_W] = in_data;
            end
        end
    end

    assign w_eop_empty  = OE_W'((RATIO - 1 - int'(w_lane)) * BEAT_B) + OE_W'(in_empty);
    assign w_word_empty = in_eop ? w_eop_empty : '0;
    assign w_load_pay   = {in_eop, w_first, w_word_empty, w_word};

    stream_out_slot #(
        .W (PAY_W)
    ) u_out_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_done),
        .i_data     (w_load_pay),
        .i_ready    (out_ready),
        .o_valid    (w_out_valid),
        .o_data     (w_slot_pay),
        .o_can_load (w_can_load)
    );

    assign {out_eop, out_sop, out_empty, out_data} = w_slot_pay;
    assign out_valid = w_out_valid;
    assign in_ready  = w_can_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_data   <= '0;
            r_acc_cnt    <= '0;
            r_in_pkt     <= 1'b0;
            r_first_word <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_cnt    <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            r_err_pulse <= w_err_nosop || w_err_dup;
            if ((w_err_nosop || w_err_dup) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_out_valid && out_ready && out_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_take) begin
                r_in_pkt <= !in_eop;
                if (w_done) begin
                    r_acc_cnt    <= '0;
                    r_acc_data   <= '0;
                    r_first_word <= 1'b0;
                end else begin
                    r_acc_cnt    <= w_lane + 1'b1;
                    r_acc_data   <= w_word;
                    r_first_word <= w_first;
                end
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign pkt_cnt   = r_pkt_cnt;

endmodule
